rvsteel_reset_sequencer: RTL and testbench

Board-level reset/halt controller placed between raw board push-buttons and the rvsteel_mcu reset/halt inputs. It replaces the single-flop button sampling with three stages:
- a 2-flop synchronizer;
- a counter-based debouncer;
- a reset-stretching FSM that guarantees a minimum MCU reset pulse.
It also gates a halt request so that halt reaches the core only while the core is running.

---
 rtl/rvsteel_debouncer.sv | 56 +++++
 rtl/rvsteel_reset_sequencer.sv | 112 +++++++++++
 tb/tb_rvsteel_reset_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rvsteel_debouncer.sv
// Input conditioner for one raw board signal: 2-flop synchronizer, optional
// polarity inversion, then a counter debouncer that only accepts a new level
// after DEBOUNCE_CYCLES consecutive cycles of disagreement with the stable one.
module rvsteel_debouncer #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter bit ACTIVE_HIGH     = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic stable_out
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
   // Synchronizer resets to the raw level of a released button.
   localparam logic [1:0] SYNC_IDLE = {2{~ACTIVE_HIGH}};

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          level;

   assign level      = ACTIVE_HIGH ? sync_q[1] : ~sync_q[1];
   assign stable_out = stable_q;

   // Count disagreement cycles; any agreeing cycle restarts the count.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (level != stable_q) begin
         if (cnt_q == TERM) begin
            stable_d = level;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer, counter and accepted level registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= SYNC_IDLE;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], raw_in};
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

endmodule

// File: rtl/rvsteel_reset_sequencer.sv
// Board-level reset/halt controller in front of rvsteel_mcu. Debounces the
// reset button and halt request, stretches every reset to a minimum length,
// holds reset while the button stays pressed, and lets halt through only
// while the core is running.
module rvsteel_reset_sequencer #(
   parameter int DEBOUNCE_CYCLES    = 120000,
   parameter int RESET_HOLD_CYCLES  = 16,
   parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       reset_button,
   input  logic       halt_request,
   output logic       mcu_reset,
   output logic       mcu_halt,
   output logic       running,
   output logic [7:0] reset_count
);

   localparam logic [1:0] S_HOLD         = 2'd0;
   localparam logic [1:0] S_WAIT_RELEASE = 2'd1;
   localparam logic [1:0] S_RUN          = 2'd2;

   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_TERM = HW'(RESET_HOLD_CYCLES - 1);

   logic          btn_stable, halt_stable;
   logic          btn_prev_q;
   logic [1:0]    state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    count_q, count_d;
   logic          mcu_reset_q, mcu_halt_q, running_q;

   rvsteel_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_HIGH    (BUTTON_ACTIVE_HIGH)
   ) u_btn_db (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (reset_button),
      .stable_out(btn_stable)
   );

   rvsteel_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_HIGH    (1'b1)
   ) u_halt_db (
      .clock     (clock),
      .reset     (reset),
      .raw_in    (halt_request),
      .stable_out(halt_stable)
   );

   assign mcu_reset   = mcu_reset_q;
   assign mcu_halt    = mcu_halt_q;
   assign running     = running_q;
   assign reset_count = count_q;

   // Next-state logic: fixed hold, wait for release, run until a new press.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      count_d = count_q;
      case (state_q)
         S_HOLD: begin
            if (hold_q == HOLD_TERM) begin
               state_d = S_WAIT_RELEASE;
               hold_d  = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         S_WAIT_RELEASE: begin
            if (!btn_stable) state_d = S_RUN;
         end
         S_RUN: begin
            if (btn_stable && !btn_prev_q) begin
               state_d = S_HOLD;
               if (count_q != 8'd255) count_d = count_q + 8'd1;
            end
         end
         default: begin
            state_d = S_HOLD;
            hold_d  = '0;
         end
      endcase
   end

   // State, counters and outputs; outputs follow the next state so they
   // move in the same cycle as the state register. Halt is only passed in
   // S_RUN, which also keeps it low whenever reset is high.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_HOLD;
         hold_q      <= '0;
         count_q     <= 8'd0;
         btn_prev_q  <= 1'b0;
         mcu_reset_q <= 1'b1;
         mcu_halt_q  <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         count_q     <= count_d;
         btn_prev_q  <= btn_stable;
         mcu_reset_q <= (state_d != S_RUN);
         mcu_halt_q  <= halt_stable & (state_d == S_RUN);
         running_q   <= (state_d == S_RUN);
      end
   end

endmodule

// File: tb/tb_rvsteel_reset_sequencer.sv
// Directed bench: a cycle-stepped vector table for power-on, glitch, button
// reset and halt gating, then hand sequences for saturation, mid-hold reset
// and an active-low button.
module tb_rvsteel_reset_sequencer;

   logic       clock = 1'b0;
   logic       reset, btn1, btn2, halt;
   logic       r1, h1, run1, r2, h2, run2;
   logic [7:0] c1, c2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   rvsteel_reset_sequencer #(
      .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4), .BUTTON_ACTIVE_HIGH(1'b1)
   ) dut1 (
      .clock(clock), .reset(reset), .reset_button(btn1), .halt_request(halt),
      .mcu_reset(r1), .mcu_halt(h1), .running(run1), .reset_count(c1)
   );

   rvsteel_reset_sequencer #(
      .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4), .BUTTON_ACTIVE_HIGH(1'b0)
   ) dut2 (
      .clock(clock), .reset(reset), .reset_button(btn2), .halt_request(halt),
      .mcu_reset(r2), .mcu_halt(h2), .running(run2), .reset_count(c2)
   );

   typedef struct {
      logic       rst, btn, hlt;
      int         cyc;
      logic       e_rst, e_hlt, e_run;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Count cycles the selected DUT holds mcu_reset high, bounded.
   task automatic pulse_len(input int which, output int n);
      n = 0;
      while (((which == 1) ? r1 : r2) === 1'b1 && n < 50) begin
         n++;
         @(negedge clock);
      end
   endtask

   initial begin
      int n;
      //           rst   btn   hlt  cyc  e_rst e_hlt e_run e_cnt
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 4,  1'b1, 1'b0, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'd0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 8'd0};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 12, 1'b0, 1'b0, 1'b1, 8'd0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b1, 8'd0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 8'd1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 4,  1'b1, 1'b0, 1'b0, 8'd1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 8'd1};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 8'd1};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 8'd1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1, 8'd1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b1, 8'd1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b1, 1'b1, 8'd1};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 10, 1'b0, 1'b1, 1'b1, 8'd1};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b0, 1'b0, 8'd2};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 30, 1'b0, 1'b0, 1'b1, 8'd2};

      btn2 = 1'b1;
      for (int i = 0; i < 17; i++) begin
         reset = tbl[i].rst;
         btn1  = tbl[i].btn;
         halt  = tbl[i].hlt;
         repeat (tbl[i].cyc) @(posedge clock);
         @(negedge clock);
         chk($sformatf("v%0d mcu_reset", i), 8'(r1), 8'(tbl[i].e_rst));
         chk($sformatf("v%0d mcu_halt", i), 8'(h1), 8'(tbl[i].e_hlt));
         chk($sformatf("v%0d running", i), 8'(run1), 8'(tbl[i].e_run));
         chk($sformatf("v%0d reset_count", i), c1, tbl[i].e_cnt);
      end

      // 260 full press/release cycles: count must stop at 255.
      for (int i = 0; i < 260; i++) begin
         btn1 = 1'b1;
         repeat (12) @(negedge clock);
         btn1 = 1'b0;
         repeat (12) @(negedge clock);
      end
      chk("sat reset_count", c1, 8'd255);
      chk("sat running", 8'(run1), 8'd1);

      // Global reset while in S_HOLD after a press.
      btn1 = 1'b1;
      repeat (12) @(negedge clock);
      chk("midhold mcu_reset", 8'(r1), 8'd1);
      chk("midhold running", 8'(run1), 8'd0);
      btn1  = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("midhold reset_count cleared", c1, 8'd0);
      pulse_len(1, n);
      chk("midhold pulse length", 8'(n), 8'd5);
      chk("midhold running after", 8'(run1), 8'd1);
      chk("midhold reset_count after", c1, 8'd0);

      // Active-low button: idle high must not reset, low press behaves like high press.
      btn2  = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      pulse_len(2, n);
      chk("al power-on pulse", 8'(n), 8'd5);
      repeat (20) @(negedge clock);
      chk("al idle running", 8'(run2), 8'd1);
      chk("al idle mcu_reset", 8'(r2), 8'd0);
      btn2 = 1'b0;
      repeat (10) @(negedge clock);
      chk("al press pre-edge", 8'(r2), 8'd0);
      @(negedge clock);
      chk("al press mcu_reset", 8'(r2), 8'd1);
      chk("al press reset_count", c2, 8'd1);
      repeat (9) @(negedge clock);
      btn2 = 1'b1;
      repeat (10) @(negedge clock);
      chk("al release held", 8'(r2), 8'd1);
      @(negedge clock);
      chk("al release mcu_reset", 8'(r2), 8'd0);
      chk("al release running", 8'(run2), 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
